// File: rtl/wireframe_pkg.sv
// Shared definitions for the wireframe edge sequencer and the register block
// that loads its tables: FSM encoding, default coordinate width and the
// field layout of packed vertex {x, y} and edge {a, b} words.
package wireframe_pkg;

  localparam int COORD_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOOKUP,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_FIN
  } state_t;

  // The second-named field of each word sits in the low bits.
  localparam int XY_Y_LSB = 0;
  localparam int AB_B_LSB = 0;

  // The x coordinate occupies the upper half of a vertex word.
  function automatic int xy_x_lsb(input int coord_w);
    return coord_w;
  endfunction

  // Vertex a occupies the upper half of an edge word.
  function automatic int ab_a_lsb(input int vi_w);
    return vi_w;
  endfunction

endpackage

// File: rtl/wireframe_table_ram.sv
// Synchronous-read table RAM: one write port and N_RD read ports sharing a
// read enable. Read registers hold their value while the enable is low and
// clear on reset so downstream outputs have a defined reset value; the
// storage array itself is left uninitialised.
module wireframe_table_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  parameter int N_RD  = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [AW-1:0]              waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       re,
  input  logic [N_RD-1:0][AW-1:0]    raddr,
  output logic [N_RD-1:0][WIDTH-1:0] rdata
);

  logic [WIDTH-1:0]           mem [DEPTH];
  logic [N_RD-1:0][WIDTH-1:0] rdata_d;
  logic [N_RD-1:0][WIDTH-1:0] rdata_q;

  // Storage write.
  // NOTE: the array has no reset branch; resetting a memory turns it into
  // thousands of flops instead of a RAM macro, and the contents are
  // defined as unknown until written anyway.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Next read data: load every port when enabled, otherwise hold.
  // NOTE: every combinational output gets a default before any branch so
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      for (int i = 0; i < N_RD; i++) rdata_d[i] = mem[raddr[i]];
    end
  end

  // Read registers.
  // NOTE: sequential state is updated with non-blocking assignments so all
  // flops sample the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wireframe_edge_sequencer.sv
// Walks the edge list on go and feeds each edge's endpoints to the line
// drawer with a start/busy handshake. Zero-length edges are counted and
// skipped because the drawer cannot terminate on them.
module wireframe_edge_sequencer
  import wireframe_pkg::*;
#(
  parameter int  MAX_VERTS = 16,
  parameter int  MAX_EDGES = 32,
  parameter int  COORD_W   = COORD_W_DEFAULT,
  localparam int VI_W      = $clog2(MAX_VERTS),
  localparam int EI_W      = $clog2(MAX_EDGES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vtx_we,
  input  logic [VI_W-1:0]      vtx_waddr,
  input  logic [2*COORD_W-1:0] vtx_wdata,
  input  logic                 edge_we,
  input  logic [EI_W-1:0]      edge_waddr,
  input  logic [2*VI_W-1:0]    edge_wdata,
  input  logic [EI_W:0]        num_edges,
  input  logic                 go,
  output logic                 busy,
  output logic                 done,
  output logic [EI_W:0]        skipped,
  output logic [COORD_W-1:0]   x0,
  output logic [COORD_W-1:0]   y0,
  output logic [COORD_W-1:0]   x1,
  output logic [COORD_W-1:0]   y1,
  output logic                 start,
  input  logic                 drawer_busy
);

  localparam int VW    = 2 * COORD_W;
  localparam int EW    = 2 * VI_W;
  localparam int X_LSB = xy_x_lsb(COORD_W);
  localparam int A_LSB = ab_a_lsb(VI_W);

  localparam logic [EI_W:0] MAX_CNT = MAX_EDGES[EI_W:0];
  localparam logic [EI_W:0] CNT_ONE = {{EI_W{1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic [EI_W:0] idx_q, idx_d;
  logic [EI_W:0] cnt_q, cnt_d;
  logic [EI_W:0] skipped_q, skipped_d;
  logic [EI_W:0] num_clamped;

  logic                     tbl_we_ok;
  logic                     edge_re;
  logic [0:0][EI_W-1:0]     edge_raddr;
  logic [0:0][EW-1:0]       edge_rd;
  logic                     vtx_re;
  logic [1:0][VI_W-1:0]     vtx_raddr;
  logic [1:0][VW-1:0]       vtx_rd;

  assign num_clamped = (num_edges > MAX_CNT) ? MAX_CNT : num_edges;
  assign tbl_we_ok   = (state_q == ST_IDLE);

  // Edge word is fetched on the edge into FETCH, for the index being entered.
  assign edge_re       = (state_d == ST_FETCH);
  assign edge_raddr[0] = idx_d[EI_W-1:0];

  wireframe_table_ram #(
    .DEPTH (MAX_EDGES),
    .WIDTH (EW),
    .N_RD  (1)
  ) u_edge_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (edge_we && tbl_we_ok),
    .waddr (edge_waddr),
    .wdata (edge_wdata),
    .re    (edge_re),
    .raddr (edge_raddr),
    .rdata (edge_rd)
  );

  // Both endpoints are read during FETCH; their read registers are the
  // coordinate outputs, so x0..y1 only move on the FETCH->LOOKUP edge.
  assign vtx_re       = (state_q == ST_FETCH);
  assign vtx_raddr[0] = edge_rd[0][A_LSB +: VI_W];
  assign vtx_raddr[1] = edge_rd[0][AB_B_LSB +: VI_W];

  wireframe_table_ram #(
    .DEPTH (MAX_VERTS),
    .WIDTH (VW),
    .N_RD  (2)
  ) u_vtx_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (vtx_we && tbl_we_ok),
    .waddr (vtx_waddr),
    .wdata (vtx_wdata),
    .re    (vtx_re),
    .raddr (vtx_raddr),
    .rdata (vtx_rd)
  );

  // Next-state and counter logic for the edge walk.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    skipped_d = skipped_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          cnt_d     = num_clamped;
          idx_d     = '0;
          skipped_d = '0;
          // An empty list still spends one busy cycle in NEXT, which then
          // terminates immediately, so done lands two cycles after go.
          state_d   = (num_clamped == '0) ? ST_NEXT : ST_FETCH;
        end
      end
      ST_FETCH:  state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (vtx_rd[0] == vtx_rd[1]) begin
          skipped_d = skipped_q + CNT_ONE;
          state_d   = ST_NEXT;
        end else begin
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE:  if (drawer_busy)  state_d = ST_WAIT;
      ST_WAIT:   if (!drawer_busy) state_d = ST_NEXT;
      ST_NEXT: begin
        idx_d   = idx_q + CNT_ONE;
        state_d = (idx_d >= cnt_q) ? ST_FIN : ST_FETCH;
      end
      ST_FIN:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      skipped_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      skipped_q <= skipped_d;
    end
  end

  assign start   = (state_q == ST_ISSUE);
  assign done    = (state_q == ST_FIN);
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign skipped = skipped_q;

  assign x0 = vtx_rd[0][X_LSB +: COORD_W];
  assign y0 = vtx_rd[0][XY_Y_LSB +: COORD_W];
  assign x1 = vtx_rd[1][X_LSB +: COORD_W];
  assign y1 = vtx_rd[1][XY_Y_LSB +: COORD_W];

endmodule

// File: tb/tb_wireframe_edge_sequencer.sv
// Directed bench for wireframe_edge_sequencer with a simple drawer model
// that holds drawer_busy high for five cycles per accepted start.
module tb_wireframe_edge_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vtx_we;
  logic [3:0]  vtx_waddr;
  logic [15:0] vtx_wdata;
  logic        edge_we;
  logic [4:0]  edge_waddr;
  logic [7:0]  edge_wdata;
  logic [5:0]  num_edges;
  logic        go;
  logic        busy;
  logic        done;
  logic [5:0]  skipped;
  logic [7:0]  x0, y0, x1, y1;
  logic        start;
  logic        drawer_busy = 1'b0;

  int checks = 0;
  int errors = 0;

  int          drw_cnt   = 0;
  int          n_starts  = 0;
  int          done_cnt  = 0;
  logic [31:0] log_q [64];

  localparam logic [31:0] E01 = 32'h0A0A_3214; // (10,10)->(50,20)
  localparam logic [31:0] E12 = 32'h3214_1E3C; // (50,20)->(30,60)
  localparam logic [31:0] E20 = 32'h1E3C_0A0A; // (30,60)->(10,10)

  wireframe_edge_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vtx_we      (vtx_we),
    .vtx_waddr   (vtx_waddr),
    .vtx_wdata   (vtx_wdata),
    .edge_we     (edge_we),
    .edge_waddr  (edge_waddr),
    .edge_wdata  (edge_wdata),
    .num_edges   (num_edges),
    .go          (go),
    .busy        (busy),
    .done        (done),
    .skipped     (skipped),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
    .start       (start),
    .drawer_busy (drawer_busy)
  );

  always #5 clk = ~clk;

  // Drawer model and done monitor, both acting on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      drw_cnt     = 0;
      drawer_busy = 1'b0;
    end else if (drw_cnt == 0) begin
      if (start) begin
        if (n_starts < 64) log_q[n_starts] = {x0, y0, x1, y1};
        n_starts++;
        drw_cnt     = 5;
        drawer_busy = 1'b1;
      end
    end else begin
      drw_cnt--;
      drawer_busy = (drw_cnt != 0);
    end
    if (rst_n && done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_vtx(input logic [3:0] idx, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    vtx_we = 1'b1; vtx_waddr = idx; vtx_wdata = {x, y};
    @(negedge clk);
    vtx_we = 1'b0;
  endtask

  task automatic write_edge(input logic [4:0] slot, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    edge_we = 1'b1; edge_waddr = slot; edge_wdata = {a, b};
    @(negedge clk);
    edge_we = 1'b0;
  endtask

  // Returns at the falling edge of the first cycle after go was sampled.
  task automatic pulse_go();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, seen, 1'b1);
    @(negedge clk);
  endtask

  task automatic clear_log();
    n_starts = 0;
    done_cnt = 0;
  endtask

  initial begin
    logic reached;

    rst_n = 1'b0; go = 1'b0; vtx_we = 1'b0; edge_we = 1'b0;
    vtx_waddr = '0; vtx_wdata = '0; edge_waddr = '0; edge_wdata = '0;
    num_edges = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_start", start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_skipped", skipped, 6'd0);
    check("rst_coords", {x0, y0, x1, y1}, 32'h0);
    rst_n = 1'b1;

    // Triangle: three edges in order, with go->start latency
    write_vtx(4'd0, 8'd10, 8'd10);
    write_vtx(4'd1, 8'd50, 8'd20);
    write_vtx(4'd2, 8'd30, 8'd60);
    write_edge(5'd0, 4'd0, 4'd1);
    write_edge(5'd1, 4'd1, 4'd2);
    write_edge(5'd2, 4'd2, 4'd0);
    num_edges = 6'd3;
    clear_log();
    pulse_go();
    check("tri_busy_after_go", busy, 1'b1);
    check("tri_no_start_fetch", start, 1'b0);
    @(negedge clk);
    check("tri_no_start_lookup", start, 1'b0);
    check("tri_coords_early", {x0, y0, x1, y1}, E01);
    @(negedge clk);
    check("tri_start_3cyc", start, 1'b1);
    wait_done("tri_done_seen", 500);
    check("tri_n_starts", n_starts, 3);
    check("tri_edge0", log_q[0], E01);
    check("tri_edge1", log_q[1], E12);
    check("tri_edge2", log_q[2], E20);
    check("tri_done_once", done_cnt, 1);
    check("tri_done_low", done, 1'b0);
    check("tri_busy_low", busy, 1'b0);
    check("tri_skipped", skipped, 6'd0);

    // Degenerate middle edge {1,1}
    write_edge(5'd1, 4'd1, 4'd1);
    clear_log();
    pulse_go();
    wait_done("deg_done_seen", 500);
    check("deg_n_starts", n_starts, 2);
    check("deg_edge0", log_q[0], E01);
    check("deg_edge1", log_q[1], E20);
    check("deg_skipped", skipped, 6'd1);
    check("deg_done_once", done_cnt, 1);

    // Empty list: one busy cycle, done two cycles after go, skipped cleared
    num_edges = 6'd0;
    clear_log();
    pulse_go();
    check("zero_busy_c1", busy, 1'b1);
    check("zero_done_c1", done, 1'b0);
    check("zero_skipped_clr", skipped, 6'd0);
    @(negedge clk);
    check("zero_done_c2", done, 1'b1);
    check("zero_busy_c2", busy, 1'b0);
    @(negedge clk);
    check("zero_done_c3", done, 1'b0);
    check("zero_no_start", n_starts, 0);

    // go and table writes while busy are ignored
    write_edge(5'd1, 4'd1, 4'd2);
    num_edges = 6'd3;
    clear_log();
    pulse_go();
    go = 1'b1;
    vtx_we = 1'b1; vtx_waddr = 4'd0; vtx_wdata = {8'd99, 8'd99};
    edge_we = 1'b1; edge_waddr = 5'd0; edge_wdata = {4'd2, 4'd2};
    @(negedge clk);
    go = 1'b0; vtx_we = 1'b0; edge_we = 1'b0;
    wait_done("busyw_done_seen", 500);
    check("busyw_n_starts", n_starts, 3);
    check("busyw_edge0", log_q[0], E01);
    check("busyw_edge2", log_q[2], E20);
    check("busyw_done_once", done_cnt, 1);
    clear_log();
    pulse_go();
    wait_done("busyw2_done_seen", 500);
    check("busyw2_n_starts", n_starts, 3);
    check("busyw2_edge0", log_q[0], E01);
    check("busyw2_edge1", log_q[1], E12);
    check("busyw2_edge2", log_q[2], E20);

    // Reset while waiting on the drawer
    clear_log();
    pulse_go();
    reached = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy && !start && drawer_busy) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rstw_reached_wait", reached, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstw_start", start, 1'b0);
    check("rstw_busy", busy, 1'b0);
    check("rstw_done", done, 1'b0);
    check("rstw_coords", {x0, y0, x1, y1}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
    pulse_go();
    wait_done("rstw_done_seen", 500);
    check("rstw_n_starts", n_starts, 3);
    check("rstw_first_edge", log_q[0], E01);

    // Oversized count clamps to the table depth
    for (int i = 0; i < 32; i++) begin
      write_edge(5'(i), 4'(i % 3), 4'((i + 1) % 3));
    end
    num_edges = 6'd40;
    clear_log();
    pulse_go();
    wait_done("clamp_done_seen", 2000);
    check("clamp_n_starts", n_starts, 32);
    check("clamp_edge0", log_q[0], E01);
    check("clamp_edge31", log_q[31], E12);
    check("clamp_skipped", skipped, 6'd0);
    check("clamp_done_once", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
